// File: rtl/pdp8_pkg.sv
// pdp8_pkg -- shared definitions for the PDP-8 group-1 operate sequencer.
//   state_e        : sequencer state encoding (IDLE, four event phases, DONE)
//   ROT_*          : opcodes driven onto the external ROTATER
//   IR_*           : bit positions of the group-1 microinstruction fields
//   is_opr1()      : true when an instruction word is a group-1 operate
package pdp8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_CMP  = 3'd2,
    ST_INC  = 3'd3,
    ST_ROT  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam logic [2:0] ROT_PASS = 3'b000;
  localparam logic [2:0] ROT_BSW  = 3'b001;
  localparam logic [2:0] ROT_RAL  = 3'b010;
  localparam logic [2:0] ROT_RTL  = 3'b011;
  localparam logic [2:0] ROT_RAR  = 3'b100;
  localparam logic [2:0] ROT_RTR  = 3'b101;

  localparam int IR_CLA   = 7;
  localparam int IR_CLL   = 6;
  localparam int IR_CMA   = 5;
  localparam int IR_CML   = 4;
  localparam int IR_RAR   = 3;
  localparam int IR_RAL   = 2;
  localparam int IR_TWICE = 1;
  localparam int IR_IAC   = 0;

  localparam logic [3:0] OPR1_GROUP = 4'b1110;

  function automatic logic is_opr1(input logic [3:0] ir_hi);
    return ir_hi == OPR1_GROUP;
  endfunction

endpackage

// File: rtl/opr1_rotsel.sv
// opr1_rotsel -- maps the rotate fields of a group-1 instruction to a
// ROTATER opcode and a flag saying whether the ROT phase is needed.
//   rar_i, ral_i, twice_i : IR rotate fields
//   rot_op_o              : ROTATER opcode (ROT_PASS when no rotate)
//   rot_en_o              : high when the ROT phase must run
// Build option OPR1_BSW_EN: when defined, TWICE alone selects byte swap
// (PDP-8/e); otherwise TWICE alone is a no-op (PDP-8/I).
module opr1_rotsel
  import pdp8_pkg::*;
(
  input  logic       rar_i,
  input  logic       ral_i,
  input  logic       twice_i,
  output logic [2:0] rot_op_o,
  output logic       rot_en_o
);

  always_comb begin
    rot_op_o = ROT_PASS;
    case ({rar_i, ral_i, twice_i})
      3'b101:  rot_op_o = ROT_RTR;
      3'b100:  rot_op_o = ROT_RAR;
      3'b011:  rot_op_o = ROT_RTL;
      3'b010:  rot_op_o = ROT_RAL;
`ifdef OPR1_BSW_EN
      3'b001:  rot_op_o = ROT_BSW;
`else
      3'b001:  rot_op_o = ROT_PASS;
`endif
      // RAR and RAL together cancel out: no rotate at all.
      default: rot_op_o = ROT_PASS;
    endcase
    rot_en_o = (rot_op_o != ROT_PASS);
  end

endmodule

// File: rtl/opr1_sequencer.sv
// opr1_sequencer -- multi-cycle sequencer for PDP-8 group-1 operate
// microinstructions. Latches IR/AC/L on START, then runs the enabled
// phases CLR -> CMP -> INC -> ROT (one cycle each) on a private AC/L copy,
// and presents the result with a one-cycle DONE pulse.
//   CLK, RESET_N        : clock, asynchronous active-low reset
//   START, IR, AC_IN, L_IN : request and operand snapshot (sampled in IDLE)
//   AC_OUT, L_OUT       : result, held until the next sequence completes
//   BUSY, DONE, ILLEGAL : status (DONE/ILLEGAL are one-cycle pulses)
//   ROT_OP, ROT_OE, ROT_AI, ROT_LI : drive to the external ROTATER
//   ROT_AO, ROT_LO      : ROTATER result, captured at the end of ROT
// Build option OPR1_BSW_EN (see opr1_rotsel): enables BSW for TWICE alone.
module opr1_sequencer
  import pdp8_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [11:0] IR,
  input  logic [11:0] AC_IN,
  input  logic        L_IN,
  output logic [11:0] AC_OUT,
  output logic        L_OUT,
  output logic        BUSY,
  output logic        DONE,
  output logic        ILLEGAL,
  output logic [2:0]  ROT_OP,
  output logic        ROT_OE,
  output logic [11:0] ROT_AI,
  output logic        ROT_LI,
  input  logic [11:0] ROT_AO,
  input  logic        ROT_LO
);

  state_e      state_q, state_d;
  logic [7:0]  ir_q, ir_d;
  logic [11:0] ac_q, ac_d;
  logic        l_q, l_d;
  logic [11:0] ac_out_q;
  logic        l_out_q;
  logic        busy_q, done_q, illegal_q, illegal_d, rot_oe_q;
  logic [2:0]  rot_op_q;
  logic        carry;

  // In IDLE the phase enables come straight from the incoming IR so the
  // first phase can be chosen at the accept edge; afterwards from the latch.
  logic [7:0]  ir_sel;
  logic        en_clr, en_cmp, en_inc, en_rot;
  logic [2:0]  rot_op_w;
  state_e      after_idle, after_clr, after_cmp, after_inc;

  assign ir_sel = (state_q == ST_IDLE) ? IR[7:0] : ir_q;
  assign en_clr = ir_sel[IR_CLA] | ir_sel[IR_CLL];
  assign en_cmp = ir_sel[IR_CMA] | ir_sel[IR_CML];
  assign en_inc = ir_sel[IR_IAC];

  opr1_rotsel u_rotsel (
    .rar_i    (ir_sel[IR_RAR]),
    .ral_i    (ir_sel[IR_RAL]),
    .twice_i  (ir_sel[IR_TWICE]),
    .rot_op_o (rot_op_w),
    .rot_en_o (en_rot)
  );

  // Next enabled phase after each position; disabled phases fall through.
  assign after_inc  = en_rot ? ST_ROT : ST_DONE;
  assign after_cmp  = en_inc ? ST_INC : after_inc;
  assign after_clr  = en_cmp ? ST_CMP : after_cmp;
  assign after_idle = en_clr ? ST_CLR : after_clr;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    ac_d      = ac_q;
    l_d       = l_q;
    illegal_d = 1'b0;
    carry     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (is_opr1(IR[11:8])) begin
            ir_d    = IR[7:0];
            ac_d    = AC_IN;
            l_d     = L_IN;
            state_d = after_idle;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_CLR: begin
        if (ir_q[IR_CLA]) ac_d = 12'o0000;
        if (ir_q[IR_CLL]) l_d  = 1'b0;
        state_d = after_clr;
      end
      ST_CMP: begin
        if (ir_q[IR_CMA]) ac_d = ~ac_q;
        if (ir_q[IR_CML]) l_d  = ~l_q;
        state_d = after_cmp;
      end
      ST_INC: begin
        {carry, ac_d} = {1'b0, ac_q} + 13'd1;
        l_d     = l_q ^ carry;
        state_d = after_inc;
      end
      ST_ROT: begin
        ac_d    = ROT_AO;
        l_d     = ROT_LO;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status and rotater controls are registered from the next state so they
  // line up exactly with the cycle the state occupies.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      ac_q      <= '0;
      l_q       <= 1'b0;
      ac_out_q  <= '0;
      l_out_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      rot_oe_q  <= 1'b0;
      rot_op_q  <= ROT_PASS;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      ac_q      <= ac_d;
      l_q       <= l_d;
      illegal_q <= illegal_d;
      busy_q    <= (state_d == ST_CLR) || (state_d == ST_CMP) ||
                   (state_d == ST_INC) || (state_d == ST_ROT);
      done_q    <= (state_d == ST_DONE);
      rot_oe_q  <= (state_d == ST_ROT);
      rot_op_q  <= (state_d == ST_ROT) ? rot_op_w : ROT_PASS;
      if (state_d == ST_DONE && state_q != ST_DONE) begin
        ac_out_q <= ac_d;
        l_out_q  <= l_d;
      end
    end
  end

  assign AC_OUT  = ac_out_q;
  assign L_OUT   = l_out_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ILLEGAL = illegal_q;
  assign ROT_OE  = rot_oe_q;
  assign ROT_OP  = rot_op_q;
  assign ROT_AI  = ac_q;
  assign ROT_LI  = l_q;

endmodule

// File: tb/tb_opr1_sequencer.sv
// tb_opr1_sequencer -- directed bench for opr1_sequencer. Provides a
// behavioural ROTATER and checks results, latency, rotater handshake,
// ILLEGAL behaviour and asynchronous reset. Expectations for IR=7002
// follow the OPR1_BSW_EN build option.
module tb_opr1_sequencer;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        START;
  logic [11:0] IR, AC_IN;
  logic        L_IN;
  logic [11:0] AC_OUT;
  logic        L_OUT, BUSY, DONE, ILLEGAL;
  logic [2:0]  ROT_OP;
  logic        ROT_OE;
  logic [11:0] ROT_AI;
  logic        ROT_LI;
  logic [11:0] ROT_AO;
  logic        ROT_LO;
  logic [12:0] rot_v;

  int vectors = 0;
  int miscompares = 0;

  opr1_sequencer dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .IR(IR), .AC_IN(AC_IN),
    .L_IN(L_IN), .AC_OUT(AC_OUT), .L_OUT(L_OUT), .BUSY(BUSY), .DONE(DONE),
    .ILLEGAL(ILLEGAL), .ROT_OP(ROT_OP), .ROT_OE(ROT_OE), .ROT_AI(ROT_AI),
    .ROT_LI(ROT_LI), .ROT_AO(ROT_AO), .ROT_LO(ROT_LO)
  );

  always #5 CLK = ~CLK;

  // Behavioural ROTATER: 13-bit rotate of {L,AC}, or byte swap of AC.
  always_comb begin
    rot_v = {ROT_LI, ROT_AI};
    case (ROT_OP)
      3'b001:  rot_v = {ROT_LI, ROT_AI[5:0], ROT_AI[11:6]};
      3'b010:  rot_v = {rot_v[11:0], rot_v[12]};
      3'b011:  rot_v = {rot_v[10:0], rot_v[12:11]};
      3'b100:  rot_v = {rot_v[0], rot_v[12:1]};
      3'b101:  rot_v = {rot_v[1:0], rot_v[12:2]};
      default: ;
    endcase
    {ROT_LO, ROT_AO} = rot_v;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  // Issues one START and waits (bounded) for DONE, sampling on negedges.
  // Returns at the negedge inside the DONE cycle; lat = 0 means timeout.
  task automatic run_op(input logic [11:0] ir, input logic [11:0] ac, input logic l,
                        output int lat, output int oe_cyc, output logic [2:0] op_seen,
                        output logic busy1, output logic overlap);
    @(negedge CLK);
    START = 1'b1; IR = ir; AC_IN = ac; L_IN = l;
    @(negedge CLK);
    START = 1'b0;
    lat = 0; oe_cyc = 0; op_seen = 3'b000; overlap = 1'b0; busy1 = BUSY;
    for (int i = 1; i <= 8; i++) begin
      if (BUSY && DONE) overlap = 1'b1;
      if (!ROT_OE && ROT_OP != 3'b000) overlap = 1'b1;
      if (ROT_OE) begin
        oe_cyc++;
        op_seen = ROT_OP;
      end
      if (DONE) begin
        lat = i;
        break;
      end
      @(negedge CLK);
    end
    $display("op IR=%04o AC=%04o L=%0d -> AC_OUT=%04o L_OUT=%0d latency=%0d rot_oe_cycles=%0d rot_op=%03b",
             ir, ac, l, AC_OUT, L_OUT, lat, oe_cyc, op_seen);
  endtask

  int         lat, oe_cyc;
  logic [2:0] op_seen;
  logic       busy1, overlap;

  initial begin
    RESET_N = 1'b1; START = 1'b0; IR = '0; AC_IN = '0; L_IN = 1'b0;
    #2 RESET_N = 1'b0;
    #2;
    check("rst_ac_out", 32'(AC_OUT), 32'o0);
    check("rst_l_out",  32'(L_OUT), 32'd0);
    check("rst_busy",   32'(BUSY), 32'd0);
    check("rst_done",   32'(DONE), 32'd0);
    check("rst_illegal", 32'(ILLEGAL), 32'd0);
    check("rst_rot_oe", 32'(ROT_OE), 32'd0);
    check("rst_rot_op", 32'(ROT_OP), 32'd0);
    @(negedge CLK); @(negedge CLK);
    RESET_N = 1'b1;

    // IAC on 7777 wraps to 0000 and complements the link.
    run_op(12'o7001, 12'o7777, 1'b0, lat, oe_cyc, op_seen, busy1, overlap);
    check("iac_latency", 32'(lat), 32'd2);
    check("iac_ac", 32'(AC_OUT), 32'o0000);
    check("iac_l", 32'(L_OUT), 32'd1);
    check("iac_busy", 32'(busy1), 32'd1);
    check("iac_oe_cycles", 32'(oe_cyc), 32'd0);
    check("iac_overlap", 32'(overlap), 32'd0);
    @(negedge CLK);
    check("iac_done_pulse", 32'(DONE), 32'd0);
    check("iac_busy_after", 32'(BUSY), 32'd0);

    // CLL then RAL: {0,4000} rotates left to L=1, AC=0000.
    run_op(12'o7104, 12'o4000, 1'b1, lat, oe_cyc, op_seen, busy1, overlap);
    check("clral_latency", 32'(lat), 32'd3);
    check("clral_oe_cycles", 32'(oe_cyc), 32'd1);
    check("clral_rot_op", 32'(op_seen), 32'b010);
    check("clral_ac", 32'(AC_OUT), 32'o0000);
    check("clral_l", 32'(L_OUT), 32'd1);
    check("clral_overlap", 32'(overlap), 32'd0);

    // CLA then CMA: AC=7777, link untouched.
    run_op(12'o7240, 12'o1234, 1'b1, lat, oe_cyc, op_seen, busy1, overlap);
    check("clacma_latency", 32'(lat), 32'd3);
    check("clacma_ac", 32'(AC_OUT), 32'o7777);
    check("clacma_l", 32'(L_OUT), 32'd1);
    check("clacma_oe_cycles", 32'(oe_cyc), 32'd0);

    // TWICE alone: byte swap or no-op depending on build.
    run_op(12'o7002, 12'o0077, 1'b0, lat, oe_cyc, op_seen, busy1, overlap);
`ifdef OPR1_BSW_EN
    check("bsw_latency", 32'(lat), 32'd2);
    check("bsw_rot_op", 32'(op_seen), 32'b001);
    check("bsw_ac", 32'(AC_OUT), 32'o7700);
`else
    check("bsw_latency", 32'(lat), 32'd1);
    check("bsw_oe_cycles", 32'(oe_cyc), 32'd0);
    check("bsw_ac", 32'(AC_OUT), 32'o0077);
    check("bsw_busy", 32'(busy1), 32'd0);
`endif
    check("bsw_l", 32'(L_OUT), 32'd0);

    // Illegal IR: ILLEGAL pulses once, nothing else moves.
    @(negedge CLK);
    START = 1'b1; IR = 12'o7402; AC_IN = 12'o5555; L_IN = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    $display("op IR=7402 -> ILLEGAL=%0d BUSY=%0d DONE=%0d AC_OUT=%04o", ILLEGAL, BUSY, DONE, AC_OUT);
    check("ill_pulse", 32'(ILLEGAL), 32'd1);
    check("ill_busy", 32'(BUSY), 32'd0);
    check("ill_done", 32'(DONE), 32'd0);
`ifdef OPR1_BSW_EN
    check("ill_ac_hold", 32'(AC_OUT), 32'o7700);
`else
    check("ill_ac_hold", 32'(AC_OUT), 32'o0077);
`endif
    check("ill_l_hold", 32'(L_OUT), 32'd0);
    @(negedge CLK);
    check("ill_pulse_end", 32'(ILLEGAL), 32'd0);
    check("ill_no_busy", 32'(BUSY), 32'd0);

    // RTR: {0,0001} rotated right twice -> L=0, AC=4000.
    run_op(12'o7012, 12'o0001, 1'b0, lat, oe_cyc, op_seen, busy1, overlap);
    check("rtr_latency", 32'(lat), 32'd2);
    check("rtr_rot_op", 32'(op_seen), 32'b101);
    check("rtr_ac", 32'(AC_OUT), 32'o4000);
    check("rtr_l", 32'(L_OUT), 32'd0);

    // Reset in the CMP phase of CLA CMA CML: outputs clear at once.
    @(negedge CLK);
    START = 1'b1; IR = 12'o7260; AC_IN = 12'o1234; L_IN = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    check("rst_mid_busy_before", 32'(BUSY), 32'd1);
    RESET_N = 1'b0;
    #1;
    $display("op IR=7260 reset in CMP -> AC_OUT=%04o L_OUT=%0d BUSY=%0d DONE=%0d", AC_OUT, L_OUT, BUSY, DONE);
    check("rst_mid_ac", 32'(AC_OUT), 32'o0);
    check("rst_mid_l", 32'(L_OUT), 32'd0);
    check("rst_mid_busy", 32'(BUSY), 32'd0);
    check("rst_mid_done", 32'(DONE), 32'd0);
    check("rst_mid_rot_oe", 32'(ROT_OE), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    run_op(12'o7001, 12'o0000, 1'b0, lat, oe_cyc, op_seen, busy1, overlap);
    check("post_rst_latency", 32'(lat), 32'd2);
    check("post_rst_ac", 32'(AC_OUT), 32'o0001);
    check("post_rst_l", 32'(L_OUT), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/opr1_sequencer.md
# opr1_sequencer

Multi-cycle sequencer for PDP-8 group-1 operate microinstructions (CLA, CLL, CMA, CML, IAC, RAR, RAL, RTR, RTL, BSW). It accepts an instruction word and an AC/L snapshot, then steps through the four PDP-8 event phases on a private AC/L copy. During the rotate phase it is the initiator of the external ROTATER: it drives `ROT_OP`, `ROT_OE`, `ROT_AI` and `ROT_LI`, and captures `ROT_AO` and `ROT_LO`. It sits between instruction decode and the AC/Link registers.

## Interface

Parameters: none.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge
- RESET_N  in  1  asynchronous, active-low reset
- START  in  1  request; sampled only in IDLE
- IR  in  12  instruction word
- AC_IN  in  12  accumulator snapshot
- L_IN  in  1  link snapshot
- AC_OUT  out  12  result accumulator
- L_OUT  out  1  result link
- BUSY  out  1  high from the cycle after accept until DONE is high
- DONE  out  1  one-cycle pulse; results valid
- ILLEGAL  out  1  one-cycle pulse; START with a non-group-1 IR
- ROT_OP  out  3  rotater opcode: 001 BSW, 010 RAL, 011 RTL, 100 RAR, 101 RTR, 000 pass
- ROT_OE  out  1  rotater output enable
- ROT_AI  out  12  rotater AC input (equals the internal AC)
- ROT_LI  out  1  rotater link input (equals the internal L)
- ROT_AO  in  12  rotater AC result
- ROT_LO  in  1  rotater link result

## Operation

- **IR bits:** 7 CLA, 6 CLL, 5 CMA, 4 CML, 3 RAR, 2 RAL, 1 TWICE, 0 IAC.
- **Legal instruction:** IR[11:8] = 4'b1110.
- **Accept, legal IR (START high in IDLE):** latch IR, AC_IN and L_IN. Go to the first enabled phase, or to DONE if no phase is enabled.
- **Reject, illegal IR (START high in IDLE):** pulse ILLEGAL. Stay in IDLE.
- **States and phase enables:**
  - IDLE
  - CLR: entered when CLA or CLL is set. CLA sets AC=0; CLL sets L=0.
  - CMP: entered when CMA or CML is set. CMA sets AC=~AC; CML sets L=~L.
  - INC: entered when IAC is set. 13-bit add AC+1. A carry out of bit 11 complements L.
  - ROT: entered when a rotate opcode is nonzero.
  - DONE
- **Phase order:** always CLR → CMP → INC → ROT. Disabled phases are skipped; each enabled phase takes exactly one cycle.
- **Rotate opcode mapping:**
  - RAR+TWICE → 101
  - RAR → 100
  - RAL+TWICE → 011
  - RAL → 010
  - TWICE alone → see Configuration
  - RAR and RAL both set → 000; the ROT phase is skipped
- **ROT phase:** ROT_OE=1 and ROT_OP=opcode. ROT_AO and ROT_LO are captured into AC and L at the end of the cycle. Outside ROT: ROT_OE=0, ROT_OP=000.
- **DONE:** AC_OUT and L_OUT are updated and held until the next accept completes. Then return to IDLE.
- **START while not in IDLE:** ignored. No queuing.

## Timing

- **Reset values:** AC_OUT=0, L_OUT=0, BUSY=0, DONE=0, ILLEGAL=0, ROT_OE=0, ROT_OP=000, state=IDLE. Reset takes effect immediately, including mid-sequence; the partial result is discarded.
- **Accept:** START accepted at edge N; first phase occupies cycle N+1.
- **Latency:** DONE is high (k+1) cycles after accept, where k = number of enabled phases (0–4). Minimum latency is 1 cycle; maximum is 5 cycles.
- **BUSY vs DONE:** never high together. A back-to-back START may be asserted in the DONE cycle's successor (IDLE).
- **ROTATER:** combinational and single-cycle. ROT_AI/ROT_LI are stable for the whole ROT cycle.

## Configuration

- **OPR1_BSW_EN defined:** TWICE alone maps to ROT_OP=001 (byte swap, PDP-8/e behaviour).
- **OPR1_BSW_EN undefined:** TWICE alone is a no-op; the ROT phase is skipped (PDP-8/I behaviour).

## Structure

- **Shared package pdp8_pkg:** state encoding, ROT_OP constants (ROT_PASS, ROT_BSW, ROT_RAL, ROT_RTL, ROT_RAR, ROT_RTR), IR bit-position constants.
- **Sub-module opr1_rotsel:** the single natural sub-module. Combinational IR → {ROT_OP, rot_en}; it contains the OPR1_BSW_EN switch.
- **Top level:** the FSM, the AC/L registers and the IAC adder.

## Test plan

- IR=7001 (octal), AC=7777, L=0 → INC only; DONE 2 cycles after accept; AC_OUT=0000, L_OUT=1.
- IR=7104, AC=4000, L=1 → CLR then ROT with ROT_OP=010, ROT_OE=1 for one cycle; AC_OUT=0000, L_OUT=1; DONE 3 cycles after accept.
- IR=7240, AC=1234, L=1 → CLR, CMP; AC_OUT=7777, L_OUT=1; ROT_OE never asserted.
- IR=7002, AC=0077 → with OPR1_BSW_EN: ROT_OP=001, AC_OUT=7700, DONE after 2 cycles. Without it: AC_OUT=0077, DONE after 1 cycle.
- IR=7402 → ILLEGAL pulses for 1 cycle; BUSY, DONE and the outputs stay unchanged. IR=7012, AC=0001, L=0 → ROT_OP=101, AC_OUT=4000, L_OUT=0.
- RESET_N low during the CMP phase of IR=7260 → all outputs 0 immediately. After release, START with IR=7001, AC=0000 → AC_OUT=0001.
